// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with round-robin replacement,
// bus-error reporting, full flush and uncached pass-through to a Wishbone master port.
module dcache_nway #(
  parameter int unsigned AW         = 24,
  parameter int unsigned DW         = 16,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_i_data,
  input  logic [DW/8-1:0] mem_sel,
  input  logic            mem_cache_enable,
  output logic            mem_ack,
  output logic            mem_err,
  output logic [DW-1:0]   mem_o_data,
  input  logic            flush_req,
  output logic            flush_done,
  output logic            wb_cyc,
  output logic            wb_stb,
  output logic            wb_we,
  output logic [AW-1:0]   wb_adr,
  output logic [DW-1:0]   wb_o_dat,
  output logic [DW/8-1:0] wb_sel,
  output logic            wb_burst,
  input  logic [DW-1:0]   wb_i_dat,
  input  logic            wb_ack,
  input  logic            wb_err
);
  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TW = AW - IW - OW;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {
    StIdle, StLookup, StEvict, StFill, StWrite, StNocache, StFlScan, StFlEvict
  } state_t;

  state_t        state;
  logic [OW-1:0] beat;
  logic          err_q, repl_q;
  logic [WW-1:0] vway, scan_way;
  logic [IW-1:0] scan_set;
  logic [DW-1:0] word_q;

  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] dirty_q [WAYS];
  logic [WW-1:0]   rr_q    [SETS];

  logic [TW-1:0] tag_mem  [WAYS][SETS];
  logic [DW-1:0] data_mem [WAYS][SETS*LINE_WORDS];
  logic [TW-1:0] tag_rd   [WAYS];
  logic [DW-1:0] data_rd  [WAYS];

  logic [OW-1:0]    off;
  logic [IW-1:0]    idx, tag_ra;
  logic [TW-1:0]    tag;
  logic [IW+OW-1:0] data_ra;
  logic             bus_done, beat_last, err_any, scan_last, scan_dirty;
  logic [OW-1:0]    beat_nx;
  logic             hit, inv_found, victim_dirty;
  logic [WW-1:0]    hit_way, inv_way, victim, rr_cur, rr_nx;

  assign off        = mem_addr[OW-1:0];
  assign idx        = mem_addr[OW +: IW];
  assign tag        = mem_addr[AW-1 -: TW];
  assign bus_done   = wb_ack | wb_err;
  assign beat_last  = (beat == OW'(LINE_WORDS - 1));
  assign beat_nx    = beat + OW'(bus_done);
  assign err_any    = err_q | wb_err;
  assign scan_last  = (scan_set == IW'(SETS - 1)) && (scan_way == WW'(WAYS - 1));
  assign scan_dirty = valid_q[scan_way][scan_set] & dirty_q[scan_way][scan_set];
  assign tag_ra     = (state == StFlScan || state == StFlEvict) ? scan_set : idx;
  assign rr_cur     = rr_q[idx];
  assign rr_nx      = (rr_cur == WW'(WAYS - 1)) ? '0 : rr_cur + WW'(1);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_rd[w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim       = inv_found ? inv_way : rr_cur;
    victim_dirty = !inv_found && dirty_q[victim][idx];
  end

  // Read addresses run one cycle ahead so the RAM output lines up with the current beat.
  always_comb begin
    unique case (state)
      StLookup:  data_ra = {idx, {OW{1'b0}}};
      StEvict:   data_ra = {idx, beat_nx};
      StFlScan:  data_ra = {scan_set, {OW{1'b0}}};
      StFlEvict: data_ra = {scan_set, beat_nx};
      default:   data_ra = {idx, off};
    endcase
  end

  always_ff @(posedge i_clk) begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd[w]  <= tag_mem[w][tag_ra];
      data_rd[w] <= data_mem[w][data_ra];
    end
    if (!i_rst) begin
      if (state == StFill && wb_ack) data_mem[vway][{idx, beat}] <= wb_i_dat;
      if (state == StFill && bus_done && beat_last && !err_any) tag_mem[vway][idx] <= tag;
      if (state == StWrite) begin
        for (int b = 0; b < SW; b++) begin
          if (mem_sel[b]) data_mem[vway][{idx, off}][b*8 +: 8] <= mem_i_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= StIdle;
      beat     <= '0;
      err_q    <= 1'b0;
      repl_q   <= 1'b0;
      vway     <= '0;
      word_q   <= '0;
      scan_set <= '0;
      scan_way <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (flush_req) begin
            state    <= StFlScan;
            scan_set <= '0;
            scan_way <= '0;
          end else if (mem_req && !mem_cache_enable) begin
            state <= StNocache;
          end else if (mem_req) begin
            state <= StLookup;
          end
        end
        StLookup: begin
          beat  <= '0;
          err_q <= 1'b0;
          if (hit) begin
            vway  <= hit_way;
            state <= mem_we ? StWrite : StIdle;
          end else begin
            vway   <= victim;
            repl_q <= !inv_found;
            state  <= victim_dirty ? StEvict : StFill;
          end
        end
        StEvict: begin
          if (bus_done) begin
            beat  <= beat_nx;
            err_q <= err_any;
            if (beat_last) begin
              err_q <= 1'b0;
              state <= err_any ? StIdle : StFill;
            end
          end
        end
        StFill: begin
          if (bus_done) begin
            beat                <= beat_nx;
            err_q               <= err_any;
            valid_q[vway][idx]  <= 1'b0;
            dirty_q[vway][idx]  <= 1'b0;
            if (beat == off) word_q <= wb_i_dat;
            if (beat_last) begin
              if (!err_any) begin
                valid_q[vway][idx] <= 1'b1;
                if (repl_q) rr_q[idx] <= rr_nx;
              end
              state <= (!err_any && mem_we) ? StWrite : StIdle;
            end
          end
        end
        StWrite: begin
          dirty_q[vway][idx] <= 1'b1;
          state              <= StIdle;
        end
        StNocache: if (bus_done) state <= StIdle;
        StFlScan: begin
          if (scan_dirty) begin
            beat  <= '0;
            state <= StFlEvict;
          end else begin
            valid_q[scan_way][scan_set] <= 1'b0;
            if (scan_last) begin
              state <= StIdle;
            end else if (scan_way == WW'(WAYS - 1)) begin
              scan_way <= '0;
              scan_set <= scan_set + IW'(1);
            end else begin
              scan_way <= scan_way + WW'(1);
            end
          end
        end
        StFlEvict: begin
          if (bus_done) begin
            beat <= beat_nx;
            if (beat_last) begin
              valid_q[scan_way][scan_set] <= 1'b0;
              dirty_q[scan_way][scan_set] <= 1'b0;
              state                       <= StFlScan;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_ack    = 1'b0;
    mem_err    = 1'b0;
    mem_o_data = '0;
    flush_done = (state == StFlScan) && !scan_dirty && scan_last;
    wb_cyc     = (state == StEvict) || (state == StFill) || (state == StNocache) ||
                 (state == StFlEvict);
    wb_stb     = wb_cyc;
    wb_we      = (state == StEvict) || (state == StFlEvict) || (state == StNocache && mem_we);
    wb_burst   = (state == StEvict) || (state == StFill) || (state == StFlEvict);
    wb_adr     = mem_addr;
    wb_o_dat   = mem_i_data;
    wb_sel     = (state == StNocache) ? mem_sel : '1;
    unique case (state)
      StLookup: begin
        mem_ack    = hit && !mem_we;
        mem_o_data = data_rd[hit_way];
      end
      StEvict: begin
        mem_ack  = bus_done && beat_last && err_any;
        mem_err  = mem_ack;
        wb_adr   = {tag_rd[vway], idx, beat};
        wb_o_dat = data_rd[vway];
      end
      StFill: begin
        mem_ack    = bus_done && beat_last && (err_any || !mem_we);
        mem_err    = mem_ack && err_any;
        mem_o_data = (beat == off) ? wb_i_dat : word_q;
        wb_adr     = {tag, idx, beat};
      end
      StWrite: mem_ack = 1'b1;
      StNocache: begin
        mem_ack    = bus_done;
        mem_err    = wb_err;
        mem_o_data = wb_i_dat;
      end
      StFlEvict: begin
        wb_adr   = {tag_rd[scan_way], scan_set, beat};
        wb_o_dat = data_rd[scan_way];
      end
      default: ;
    endcase
  end
endmodule
